div_issue_ctrl: RTL
===================

// Module: div_issue_ctrl
// PURPOSE
// Initiator side of the divider handshake: takes DIV/DIVU/REM/REMU ops from EX and issues them to div_unit.
// Waits for div_unit's done pulse, holds the result and arbitrates it onto the shared regfile write-back port.
// Drives the EX stall and the ID RAW-hazard flag for the destination register that is still pending.
// PARAMETERS
// XLEN        32  operand/result width
// BLOCKING    1   1: stall EX from accept until write-back done; 0: release EX after issue
// TIMEOUT_CYC 64  WAIT-state cycles allowed before the op is declared hung
// PORTS
// clk           in   1     core clock
// reset_n       in   1     async active-low reset
// ex_valid_i    in   1     EX holds a valid instruction
// ex_div_i      in   1     EX instruction is an M-ext divide op
// ex_funct3_i   in   3     100 DIV, 101 DIVU, 110 REM, 111 REMU
// ex_rs1_i      in   XLEN  dividend
// ex_rs2_i      in   XLEN  divisor
// ex_rd_i       in   5     destination register
// ex_stall_o    out  1     hold EX
// id_rs1_addr_i in   5     ID source 1 address
// id_rs2_addr_i in   5     ID source 2 address
// hazard_o      out  1     ID source matches pending rd
// flush_i       in   1     squash the in-flight div op
// div_start_o   out  1     to div_unit start_i/valid_i, one-cycle pulse
// div_flush_o   out  1     to div_unit flush_i, one-cycle pulse
// div_funct3_o  out  3     registered op to div_unit
// div_rs1_o     out  XLEN  registered dividend to div_unit
// div_rs2_o     out  XLEN  registered divisor to div_unit
// div_rd_o      out  5     registered rd to div_unit
// div_ready_i   in   1     div_unit done pulse
// div_busy_i    in   1     div_unit busy
// div_result_i  in   XLEN  div_unit result, valid with div_ready_i
// wb_req_o      out  1     write-back request
// wb_rd_o       out  5     write-back address
// wb_data_o     out  XLEN  write-back data
// wb_gnt_i      in   1     write-back grant
// error_o       out  1     sticky timeout flag
// BEHAVIOUR
// - Reset: state=IDLE; pending=0; all outputs 0; operand, result and timeout registers cleared.
// - FSM:
//   - IDLE -> ISSUE when ex_valid_i & ex_div_i & ~flush_i & ~div_busy_i.
//     On that edge, register funct3, rs1, rs2 and rd; set pending.
//   - ISSUE: div_start_o=1 for exactly this cycle, then -> WAIT.
//     div_* operands stay stable from ISSUE until the op leaves WAIT.
//   - WAIT: on div_ready_i, capture div_result_i into the result register.
//     Next state is WB if rd!=0; if rd==0, go to IDLE with pending cleared and no write-back.
//   - WB: wb_req_o=1 with wb_rd_o/wb_data_o held stable until wb_gnt_i.
//     On the grant edge -> IDLE and pending cleared. wb_req_o drops the cycle after the grant.
// - Latency: accept edge t0; start pulse in cycle t0+1.
//   Earliest wb_req_o is the cycle after div_ready_i (divide-by-zero: a few cycles; normal: ~XLEN+3).
// - ex_stall_o:
//   - BLOCKING=1: asserted when ex_valid_i & ex_div_i and state!=IDLE, or in the accept cycle.
//     EX therefore holds the op until write-back completes.
//   - BLOCKING=0: asserted only when a new div op is presented while state!=IDLE.
// - hazard_o (combinational): pending & rd!=0 & (id_rs1_addr_i==rd | id_rs2_addr_i==rd).
//   Stays asserted through the grant cycle.
// - flush_i:
//   - In ISSUE or WAIT: div_flush_o pulses next cycle, op dropped, pending cleared, -> IDLE.
//     A div_ready_i arriving in the flush cycle is ignored.
//   - In WB: ignored, because the op is architecturally complete.
//   - In IDLE: blocks accept.
//   - Flush and accept in the same cycle: flush wins, nothing is accepted.
// - Timeout: a counter runs in WAIT and resets on leaving WAIT.
//   At TIMEOUT_CYC: div_flush_o pulse, error_o set (sticky until reset), pending cleared, -> IDLE.
// - Result data is passed through unmodified; sign, divide-by-zero and overflow rules belong to div_unit.
// - Async reset mid-op returns to IDLE immediately; div_unit is reset by the same reset_n.
// TESTING
// - DIVU 100/7, rd=5, wb_gnt_i tied high -> one start pulse; wb_req_o with rd=5, data=14; pending clears after grant.
// - DIV -7/2 then REM -7/2 back-to-back, BLOCKING=1 -> ex_stall_o holds the 2nd op; results 0xFFFFFFFD, 0xFFFFFFFF in order.
// - DIVU 5/0, rd=3 -> wb_data_o=0xFFFFFFFF within 5 cycles of start; REMU 5/0 -> 5.
// - Flush 10 cycles into WAIT -> div_flush_o pulse, no wb_req_o, hazard_o low, next op accepted.
// - rd=0 DIV 0x80000000/-1 -> no wb_req_o; hazard_o never asserts even with id_rs1_addr_i=0.
// - div_ready_i held low (model) -> error_o at WAIT cycle 64 with a div_flush_o pulse; wb_gnt_i delayed 4 cycles in WB keeps data stable.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - divider issue/write-back controller between EX and div_unit
//
// Purpose: accepts DIV/DIVU/REM/REMU ops from EX, issues them to div_unit with
// a one-cycle start pulse, waits for the done pulse, holds the result and
// requests the shared regfile write-back port. Drives the EX stall, the ID
// RAW-hazard flag for the pending rd, and a sticky timeout error.
//
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   ex_valid_i, ex_div_i, ex_funct3_i    EX op qualifiers
//   ex_rs1_i, ex_rs2_i, ex_rd_i          EX operands and destination
//   ex_stall_o                           hold EX
//   id_rs1_addr_i, id_rs2_addr_i         ID source addresses
//   hazard_o                             ID source matches pending rd
//   flush_i                              squash in-flight op
//   div_start_o, div_flush_o             one-cycle pulses to div_unit
//   div_funct3_o, div_rs1_o, div_rs2_o,
//   div_rd_o                             registered op to div_unit
//   div_ready_i, div_busy_i, div_result_i  div_unit status/result
//   wb_req_o, wb_rd_o, wb_data_o, wb_gnt_i write-back port
//   error_o                              sticky timeout flag

module div_issue_ctrl #(
    parameter int XLEN        = 32,
    parameter bit BLOCKING    = 1'b1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ex_valid_i,
    input  logic            ex_div_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_rs1_i,
    input  logic [XLEN-1:0] ex_rs2_i,
    input  logic [4:0]      ex_rd_i,
    output logic            ex_stall_o,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    output logic            hazard_o,
    input  logic            flush_i,
    output logic            div_start_o,
    output logic            div_flush_o,
    output logic [2:0]      div_funct3_o,
    output logic [XLEN-1:0] div_rs1_o,
    output logic [XLEN-1:0] div_rs2_o,
    output logic [4:0]      div_rd_o,
    input  logic            div_ready_i,
    input  logic            div_busy_i,
    input  logic [XLEN-1:0] div_result_i,
    output logic            wb_req_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    input  logic            wb_gnt_i,
    output logic            error_o
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_pending;
    logic            r_retire;
    logic            r_div_start;
    logic            r_div_flush;
    logic            r_wb_req;
    logic            r_error;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_result;
    logic [TW-1:0]   r_tmo_cnt;

    logic w_div_op;
    logic w_not_idle;
    logic w_accept;
    logic w_busy_hold;
    logic w_rd_nz;
    logic w_tmo_hit;

    assign w_div_op   = ex_valid_i & ex_div_i;
    assign w_not_idle = (r_state != S_IDLE);
    assign w_rd_nz    = |r_rd;
    assign w_tmo_hit  = (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // r_retire marks the one IDLE cycle after completion in blocking mode:
    // EX still holds the op just finished, so it must be let go rather than
    // accepted a second time.
    assign w_accept = (r_state == S_IDLE) & w_div_op & ~flush_i & ~div_busy_i & ~r_retire;

    // div_unit still busy while we sit idle (e.g. draining after a flush):
    // hold the op instead of letting it slip past unissued.
    assign w_busy_hold = (r_state == S_IDLE) & w_div_op & div_busy_i & ~flush_i & ~r_retire;

    assign ex_stall_o = BLOCKING ? ((w_div_op & w_not_idle) | w_accept | w_busy_hold)
                                 : ((w_div_op & w_not_idle) | w_busy_hold);

    assign hazard_o = r_pending & w_rd_nz &
                      ((id_rs1_addr_i == r_rd) | (id_rs2_addr_i == r_rd));

    assign div_start_o  = r_div_start;
    assign div_flush_o  = r_div_flush;
    assign div_funct3_o = r_funct3;
    assign div_rs1_o    = r_rs1;
    assign div_rs2_o    = r_rs2;
    assign div_rd_o     = r_rd;
    assign wb_req_o     = r_wb_req;
    assign wb_rd_o      = r_rd;
    assign wb_data_o    = r_result;
    assign error_o      = r_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pending   <= 1'b0;
            r_retire    <= 1'b0;
            r_div_start <= 1'b0;
            r_div_flush <= 1'b0;
            r_wb_req    <= 1'b0;
            r_error     <= 1'b0;
            r_funct3    <= 3'd0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= 5'd0;
            r_result    <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            r_div_start <= 1'b0;
            r_div_flush <= 1'b0;
            r_retire    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3    <= ex_funct3_i;
                        r_rs1       <= ex_rs1_i;
                        r_rs2       <= ex_rs2_i;
                        r_rd        <= ex_rd_i;
                        r_pending   <= 1'b1;
                        r_div_start <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_tmo_cnt <= '0;
                    if (flush_i) begin
                        r_div_flush <= 1'b1;
                        r_pending   <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // Flush beats a coincident done pulse; done beats timeout.
                    if (flush_i) begin
                        r_div_flush <= 1'b1;
                        r_pending   <= 1'b0;
                        r_tmo_cnt   <= '0;
                        r_state     <= S_IDLE;
                    end else if (div_ready_i) begin
                        r_result  <= div_result_i;
                        r_tmo_cnt <= '0;
                        if (w_rd_nz) begin
                            r_wb_req <= 1'b1;
                            r_state  <= S_WB;
                        end else begin
                            r_pending <= 1'b0;
                            r_retire  <= BLOCKING;
                            r_state   <= S_IDLE;
                        end
                    end else if (w_tmo_hit) begin
                        r_div_flush <= 1'b1;
                        r_error     <= 1'b1;
                        r_pending   <= 1'b0;
                        r_retire    <= BLOCKING;
                        r_tmo_cnt   <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                S_WB: begin
                    // flush_i is ignored here: the op is architecturally complete.
                    if (wb_gnt_i) begin
                        r_wb_req  <= 1'b0;
                        r_pending <= 1'b0;
                        r_retire  <= BLOCKING;
                        r_state   <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
